// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the run/step controller: FSM encoding and
// free-run rate multipliers.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_PAUSE = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

   localparam int MULT_SLOW = 100;
   localparam int MULT_MED  = 10;
   localparam int MULT_FAST = 1;
   localparam logic [1:0] RATE_EVERY = 2'd3;

   // Ticks per cpu_en pulse for a given rate code.
   function automatic int rate_div(input logic [1:0] sel, input int base_div);
      int div;
      case (sel)
         2'd0:    div = base_div * MULT_SLOW;
         2'd1:    div = base_div * MULT_MED;
         2'd2:    div = base_div * MULT_FAST;
         default: div = 1;
      endcase
      return div;
   endfunction

endpackage

// File: rtl/run_ctrl_debounce.sv
// Two-flop synchronizer followed by a stability counter; the output only
// follows the input after it has differed for DEB_CYCLES consecutive cycles.
module debounce #(
   parameter int DEB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             db_q, db_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = din;
      sync2_d = sync1_q;
      db_d    = db_q;
      cnt_d   = '0;
      // Any cycle where the synchronized value agrees restarts the count.
      if (sync2_q != db_q) begin
         if (cnt_q == CNT_LAST) db_d = sync2_q;
         else                   cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         db_q    <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         db_q    <= db_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dout = db_q;

endmodule

// File: rtl/run_ctrl.sv
// Run/step controller for the MIPS core: debounced switch and button drive a
// PAUSE/RUN/STEP/HOLD FSM that emits single-cycle cpu_en pulses.
module run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = 1000000,
   parameter int BASE_DIV   = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run_sw,
   input  logic        step_btn,
   input  logic [1:0]  rate_sel,
   output logic        cpu_en,
   output logic        running,
   output logic [15:0] step_cnt,
   output logic [1:0]  state_dbg
);

   localparam int TICK_W = $clog2(BASE_DIV * MULT_SLOW);

   state_e            state_q, state_d;
   logic [TICK_W-1:0] tick_q, tick_d;
   logic [1:0]        rate_q, rate_d;
   logic              cpu_en_q, cpu_en_d;
   logic              running_q, running_d;
   logic [15:0]       step_cnt_q, step_cnt_d;
   logic              step_prev_q, step_prev_d;

   logic              db_run, db_step, step_req;
   logic              rate_chg, tick_hit, stay_run;
   logic [TICK_W-1:0] div_m1;

   debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
      .clk(clk), .rst_n(rst_n), .din(run_sw), .dout(db_run)
   );

   debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
      .clk(clk), .rst_n(rst_n), .din(step_btn), .dout(db_step)
   );

   always_comb begin
      step_req    = db_step & ~step_prev_q;
      step_prev_d = db_step;
      rate_d      = rate_sel;
      rate_chg    = (rate_sel != rate_q);
      div_m1      = TICK_W'(rate_div(rate_sel, BASE_DIV) - 1);
      tick_hit    = (tick_q == div_m1);

      state_d = state_q;
      case (state_q)
         ST_PAUSE: begin
            if (db_run)        state_d = ST_RUN;
            else if (step_req) state_d = ST_STEP;
         end
         ST_RUN:  if (!db_run)  state_d = ST_PAUSE;
         ST_STEP:               state_d = ST_HOLD;
         ST_HOLD: if (!db_step) state_d = ST_PAUSE;
         default:               state_d = ST_PAUSE;
      endcase

      // A tick only fires while RUN persists, so leaving RUN never leaks a pulse.
      stay_run = (state_q == ST_RUN) && (state_d == ST_RUN);
      tick_d   = '0;
      if (stay_run && !rate_chg && !tick_hit) tick_d = tick_q + 1'b1;

      cpu_en_d   = (state_d == ST_STEP) || (stay_run && !rate_chg && tick_hit);
      running_d  = (state_d == ST_RUN);
      step_cnt_d = step_cnt_q + {15'd0, cpu_en_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_PAUSE;
         tick_q      <= '0;
         rate_q      <= 2'd0;
         cpu_en_q    <= 1'b0;
         running_q   <= 1'b0;
         step_cnt_q  <= 16'd0;
         step_prev_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         rate_q      <= rate_d;
         cpu_en_q    <= cpu_en_d;
         running_q   <= running_d;
         step_cnt_q  <= step_cnt_d;
         step_prev_q <= step_prev_d;
      end
   end

   assign cpu_en    = cpu_en_q;
   assign running   = running_q;
   assign step_cnt  = step_cnt_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl with DEB_CYCLES=4, BASE_DIV=3.
module tb_run_ctrl;
   import run_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run_sw;
   logic        step_btn;
   logic [1:0]  rate_sel;
   logic        cpu_en;
   logic        running;
   logic [15:0] step_cnt;
   logic [1:0]  state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      int width;
      int exp_pulses;
   } step_vec_t;

   run_ctrl #(.DEB_CYCLES(4), .BASE_DIV(3)) dut (
      .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .step_btn(step_btn),
      .rate_sel(rate_sel), .cpu_en(cpu_en), .running(running),
      .step_cnt(step_cnt), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n && cpu_en) pulse_cnt++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_running(input logic val, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk);
         if (running === val) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      step_vec_t vecs[6];
      int   exp_total;
      int   p0;
      bit   ok;
      logic [31:0] e;

      vecs[0] = '{10, 1};
      vecs[1] = '{3, 0};
      vecs[2] = '{1, 0};
      vecs[3] = '{4, 1};
      vecs[4] = '{2, 0};
      vecs[5] = '{6, 1};

      rst_n = 1'b0; run_sw = 1'b0; step_btn = 1'b0; rate_sel = 2'd2;
      cycles(3);
      check("reset_cpu_en", {31'd0, cpu_en}, 0);
      check("reset_running", {31'd0, running}, 0);
      check("reset_step_cnt", {16'd0, step_cnt}, 0);
      check("reset_state", {30'd0, state_dbg}, {30'd0, ST_PAUSE});
      rst_n = 1'b1;
      cycles(2);

      // step button presses of varying width
      exp_total = 0;
      foreach (vecs[i]) begin
         exp_total += vecs[i].exp_pulses;
         exp_q.push_back(exp_total);
         p0 = pulse_cnt;
         step_btn = 1'b1;
         cycles(vecs[i].width);
         step_btn = 1'b0;
         cycles(25);
         check($sformatf("step_pulses_w%0d", vecs[i].width), pulse_cnt - p0, vecs[i].exp_pulses);
         e = exp_q.pop_front();
         check($sformatf("step_cnt_w%0d", vecs[i].width), {16'd0, step_cnt}, e);
         check($sformatf("step_state_w%0d", vecs[i].width), {30'd0, state_dbg}, {30'd0, ST_PAUSE});
      end

      // free run at rate 2: one pulse every 3 cycles
      rate_sel = 2'd2;
      run_sw = 1'b1;
      wait_running(1'b1, 20, ok);
      check("run2_entry", {31'd0, ok}, 1);
      for (int k = 1; k <= 30; k++) begin
         exp_q.push_back((k % 3 == 0) ? 32'd1 : 32'd0);
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("run2_cpu_en_k%0d", k), {31'd0, cpu_en}, e);
         check("run2_running", {31'd0, running}, 1);
      end
      run_sw = 1'b0;
      wait_running(1'b0, 20, ok);
      check("run2_exit", {31'd0, ok}, 1);
      p0 = pulse_cnt;
      cycles(12);
      check("run2_no_pulse_after_exit", pulse_cnt - p0, 0);

      // rate change mid-count: div 300 abandoned at count 150, then every cycle
      rate_sel = 2'd0;
      cycles(2);
      run_sw = 1'b1;
      wait_running(1'b1, 20, ok);
      check("run0_entry", {31'd0, ok}, 1);
      for (int k = 1; k <= 320; k++) begin
         exp_q.push_back((k >= 152) ? 32'd1 : 32'd0);
         @(negedge clk);
         e = exp_q.pop_front();
         check($sformatf("rate_chg_cpu_en_k%0d", k), {31'd0, cpu_en}, e);
         if (k == 150) rate_sel = 2'd3;
      end

      // step_cnt wrap at rate 3
      ok = 1'b0;
      for (int i = 0; i < 70000; i++) begin
         @(negedge clk);
         if (step_cnt === 16'hFFFF) begin
            ok = 1'b1;
            break;
         end
      end
      check("wrap_reached_ffff", {31'd0, ok}, 1);
      @(negedge clk);
      check("wrap_to_zero", {16'd0, step_cnt}, 0);
      @(negedge clk);
      check("wrap_then_one", {16'd0, step_cnt}, 1);

      // asynchronous reset during RUN
      check("pre_reset_cpu_en", {31'd0, cpu_en}, 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_cpu_en", {31'd0, cpu_en}, 0);
      check("async_rst_running", {31'd0, running}, 0);
      check("async_rst_step_cnt", {16'd0, step_cnt}, 0);
      check("async_rst_state", {30'd0, state_dbg}, {30'd0, ST_PAUSE});
      cycles(2);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         check($sformatf("post_rst_running_k%0d", k), {31'd0, running}, 0);
         check($sformatf("post_rst_cpu_en_k%0d", k), {31'd0, cpu_en}, 0);
      end
      wait_running(1'b1, 10, ok);
      check("post_rst_run_entry", {31'd0, ok}, 1);
      @(negedge clk);
      check("post_rst_first_pulse", {31'd0, cpu_en}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 1000000: cycles an input must hold stable before the debounced value changes.
REQ-002 Parameter BASE_DIV, default 1000000: base divisor for run-rate ticks.
REQ-003 clk  input  1  sole clock for the block (100 MHz board clock).
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low; no other reset source.
REQ-005 run_sw  input  1  raw slide switch; 1 = free-run, 0 = paused.
REQ-006 step_btn  input  1  raw push button; each debounced press requests one instruction step.
REQ-007 rate_sel  input  2  free-run rate select.
REQ-008 cpu_en  output  1  one-cycle clock-enable pulse to the MIPS core; one pulse = one instruction advance.
REQ-009 running  output  1  high while the FSM is in RUN (LED drive).
REQ-010 step_cnt  output  16  count of cpu_en pulses issued since reset, for the 7-segment display.

Function
REQ-011 run_sw and step_btn SHALL each pass a 2-flop synchronizer, then a debouncer: debounced value updates only after the synchronized value differs from it for DEB_CYCLES consecutive cycles; any reversion clears the counter.
REQ-012 Step request SHALL be the rising edge of debounced step_btn, exactly one per press regardless of hold time.
REQ-013 Run divisor SHALL be: rate_sel 0 -> BASE_DIV*100, 1 -> BASE_DIV*10, 2 -> BASE_DIV, 3 -> 1 (every cycle); tick counter width SHALL cover BASE_DIV*100-1.
REQ-014 FSM states: PAUSE, RUN, STEP, HOLD; reset state PAUSE.
REQ-015 PAUSE: debounced run_sw=1 -> RUN; else step request -> STEP; else stay.
REQ-016 RUN: debounced run_sw=0 -> PAUSE; step requests ignored.
REQ-017 STEP: cpu_en=1 for exactly this cycle; next state HOLD unconditionally.
REQ-018 HOLD: wait until debounced step_btn=0, then -> PAUSE; run_sw=1 here is honoured only after returning to PAUSE.
REQ-019 In RUN the tick counter SHALL count 0..divisor-1; cpu_en=1 in the cycle it equals divisor-1, then the counter wraps to 0.
REQ-020 Tick counter SHALL clear to 0 on entering RUN and on any rate_sel change; first pulse after entering RUN therefore comes divisor cycles later (rate 3: the cycle after entry).
REQ-021 rate_sel is sampled directly (no debounce); a change mid-count discards the partial count, no extra pulse.
REQ-022 cpu_en SHALL be registered; never high in PAUSE or HOLD; at most one cycle high per tick or step.
REQ-023 step_cnt SHALL increment by 1 in the cycle after each cpu_en pulse and wrap 0xFFFF -> 0x0000.
REQ-024 running SHALL equal (state == RUN), registered.

Reset
REQ-025 rst_n low SHALL immediately force: state PAUSE, cpu_en 0, running 0, step_cnt 0, tick counter 0, synchronizers, debounced values and debounce counters 0.
REQ-026 Reset mid-RUN or mid-STEP SHALL cancel any pending pulse; no cpu_en in the first cycle after release.
REQ-027 After release, a switch already high SHALL take 2 + DEB_CYCLES cycles before RUN is entered.

Structure
REQ-028 State encoding and rate-select multipliers (100, 10, 1, and the divisor-of-1 code) SHALL live in shared package run_ctrl_pkg.
REQ-029 Debouncer SHALL be sub-module debounce (synchronizer + counter), instantiated twice.
REQ-030 No derived or gated clocks; the core is advanced solely by cpu_en on clk.

Verification (DEB_CYCLES=4, BASE_DIV=3)
REQ-031 Reset, run_sw=0, step_btn pulsed high 10 cycles -> exactly one cpu_en, step_cnt=1, final state PAUSE.
REQ-032 step_btn glitch high 3 cycles -> no cpu_en, step_cnt=0.
REQ-033 run_sw=1, rate_sel=2 for 30 cycles after debounce -> cpu_en every 3 cycles, running=1; run_sw=0 -> pulses stop after debounce.
REQ-034 RUN at rate_sel=0 (div 300), switch to rate_sel=3 at count 150 -> no pulse at 300, pulses every cycle thereafter.
REQ-035 step_cnt preloaded via 65535 pulses at rate_sel=3, one more -> step_cnt=0x0000.
REQ-036 rst_n asserted during RUN -> cpu_en, running and step_cnt 0 in the same cycle; after release no pulse until 2+4 cycles of run_sw=1.
